// File: rtl/timer_ctrl_pkg.sv
// Shared constants for the interval-timer controller.
// Register map, CTRL/STATUS bit positions and FSM encoding.
package timer_pkg;

    localparam int TMR_WIDTH = 32;
    localparam int TMR_PSC_W = 8;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LIMIT  = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_PER_BIT = 1;
    localparam int CTRL_PSC_LSB = 8;

    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_RUN_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// Register bus and interrupt signals between CPU and timer.
// master = CPU side, slave = timer side.
interface timer_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_wdata;
    logic [WIDTH-1:0] cfg_rdata;
    logic             irq_ack;
    logic             irq;
    logic             tick;
    logic [WIDTH-1:0] count;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, irq_ack,
        input  cfg_rdata, irq, tick, count
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, irq_ack,
        output cfg_rdata, irq, tick, count
    );
endinterface

// File: rtl/timer_ctrl_prescaler.sv
// Clock prescaler: emits one adv pulse every p+1 running cycles.
// clear restarts the phase and suppresses the pulse for that cycle.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = TMR_PSC_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] p,
    output logic                  adv
);

    logic [PRESCALE_W-1:0] psc_q;
    logic [PRESCALE_W-1:0] psc_d;

    always_comb begin
        psc_d = psc_q;
        adv   = 1'b0;
        if (clear) begin
            psc_d = '0;
        end else if (run) begin
            if (psc_q == p) begin
                psc_d = '0;
                adv   = 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer: wrap-at-limit count, one-shot or
// periodic, prescaled, with a sticky pending interrupt.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH      = TMR_WIDTH,
    parameter int PRESCALE_W = TMR_PSC_W
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);

    state_e                state_q, state_d;
    logic                  ctrl_en_q, ctrl_en_d;
    logic                  ctrl_per_q, ctrl_per_d;
    logic [PRESCALE_W-1:0] ctrl_p_q, ctrl_p_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic                  pending_q, pending_d;
    logic                  tick_q, tick_d;

    logic             ctrl_wr;
    logic             limit_wr;
    logic             count_wr;
    logic             status_wr;
    logic             wr_en;
    logic             running;
    logic             psc_clear;
    logic             psc_run;
    logic             adv;
    logic             expire;
    logic             pend_clr;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] rdata;

    assign ctrl_wr   = bus.cfg_we && (bus.cfg_addr == ADDR_CTRL);
    assign limit_wr  = bus.cfg_we && (bus.cfg_addr == ADDR_LIMIT);
    assign count_wr  = bus.cfg_we && (bus.cfg_addr == ADDR_COUNT);
    assign status_wr = bus.cfg_we && (bus.cfg_addr == ADDR_STATUS);
    assign wr_en     = bus.cfg_wdata[CTRL_EN_BIT];
    assign running   = (state_q == RUN);

    // A CTRL write either restarts the phase or freezes the count.
    assign psc_clear = (ctrl_wr && wr_en) || count_wr;
    assign psc_run   = running && !ctrl_wr;

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_psc (
        .clk   (clk),
        .reset (reset),
        .clear (psc_clear),
        .run   (psc_run),
        .p     (ctrl_p_q),
        .adv   (adv)
    );

    assign nxt      = count_q + 1'b1;
    assign expire   = adv && (nxt == limit_q);
    assign pend_clr = bus.irq_ack
                   || (status_wr && bus.cfg_wdata[STAT_PEND_BIT]);

    always_comb begin
        state_d    = state_q;
        ctrl_en_d  = ctrl_en_q;
        ctrl_per_d = ctrl_per_q;
        ctrl_p_d   = ctrl_p_q;
        limit_d    = limit_q;
        count_d    = count_q;
        pending_d  = pending_q;
        tick_d     = expire;

        if (count_wr) begin
            count_d = bus.cfg_wdata;
        end else if (adv) begin
            count_d = expire ? '0 : nxt;
        end

        if (limit_wr) begin
            limit_d = bus.cfg_wdata;
        end

        if (ctrl_wr) begin
            ctrl_en_d  = wr_en;
            ctrl_per_d = bus.cfg_wdata[CTRL_PER_BIT];
            ctrl_p_d   = bus.cfg_wdata[CTRL_PSC_LSB +: PRESCALE_W];
        end

        // Expiry outranks a same-cycle clear.
        if (expire) begin
            pending_d = 1'b1;
        end else if (pend_clr) begin
            pending_d = 1'b0;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (ctrl_wr && wr_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ctrl_wr) begin
                    state_d = wr_en ? RUN : IDLE;
                end else if (expire && !ctrl_per_q) begin
                    state_d   = DONE;
                    ctrl_en_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        unique case (bus.cfg_addr)
            ADDR_CTRL: begin
                rdata[CTRL_EN_BIT]  = ctrl_en_q;
                rdata[CTRL_PER_BIT] = ctrl_per_q;
                rdata[CTRL_PSC_LSB +: PRESCALE_W] = ctrl_p_q;
            end
            ADDR_LIMIT: rdata = limit_q;
            ADDR_COUNT: rdata = count_q;
            ADDR_STATUS: begin
                rdata[STAT_PEND_BIT] = pending_q;
                rdata[STAT_RUN_BIT]  = running;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_en_q  <= 1'b0;
            ctrl_per_q <= 1'b0;
            ctrl_p_q   <= '0;
            limit_q    <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_per_q <= ctrl_per_d;
            ctrl_p_q   <= ctrl_p_d;
            limit_q    <= limit_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.cfg_rdata = rdata;
    assign bus.irq       = pending_q;
    assign bus.tick      = tick_q;
    assign bus.count     = count_q;

endmodule
